// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared widths, operand bundle type and operand select helper
package operand_fetch_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;
    localparam int CTRL_W   = 16;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        reg_idx_t          rd;
        logic              wr;
        logic [CTRL_W-1:0] ctrl;
    } of_bundle_t;

    // x0 reads as zero; a same-beat writeback wins over the not-yet-updated register file
    function automatic logic [XLEN-1:0] operand_select(
        input reg_idx_t        idx,
        input logic [XLEN-1:0] rf_data,
        input logic            wb_valid,
        input reg_idx_t        wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        if (idx == '0) begin
            return '0;
        end else if (wb_valid && (wb_rd == idx)) begin
            return wb_data;
        end
        return rf_data;
    endfunction

endpackage

// File: rtl/of_scoreboard.sv
// rtl/of_scoreboard.sv - pending-write scoreboard with writeback-masked lookups
module of_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     flush_clr_en,
    input  reg_idx_t flush_clr_idx,
    input  logic     wb_valid,
    input  reg_idx_t wb_rd,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    input  reg_idx_t rd,
    output logic     eff_rs1,
    output logic     eff_rs2,
    output logic     eff_rd
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_d;

    // set is applied last so a new writer claiming a register beats its retiring writeback
    always_comb begin
        pending_d = pending;
        if (wb_valid) begin
            pending_d[wb_rd] = 1'b0;
        end
        if (flush_clr_en) begin
            pending_d[flush_clr_idx] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_idx] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_d;
        end
    end

    assign eff_rs1 = pending[rs1] && !(wb_valid && (wb_rd == rs1) && (rs1 != '0));
    assign eff_rs2 = pending[rs2] && !(wb_valid && (wb_rd == rs2) && (rs2 != '0));
    assign eff_rd  = pending[rd]  && !(wb_valid && (wb_rd == rd)  && (rd  != '0));

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage: hazard stall, writeback bypass, registered bundle
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  reg_idx_t          dec_rs1_i,
    input  reg_idx_t          dec_rs2_i,
    input  logic              dec_use_rs1_i,
    input  logic              dec_use_rs2_i,
    input  reg_idx_t          dec_rd_i,
    input  logic              dec_wr_i,
    input  logic [CTRL_W-1:0] dec_ctrl_i,
    output reg_idx_t          rf_rs1_o,
    output reg_idx_t          rf_rs2_o,
    input  logic [XLEN-1:0]   rf_rs1_data_i,
    input  logic [XLEN-1:0]   rf_rs2_data_i,
    input  logic              wb_valid_i,
    input  reg_idx_t          wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   ex_op1_o,
    output logic [XLEN-1:0]   ex_op2_o,
    output reg_idx_t          ex_rd_o,
    output logic              ex_wr_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [31:0]       stall_cnt_o
);

    of_bundle_t  bundle_q;
    of_bundle_t  bundle_d;
    logic        ex_valid_q;
    logic [31:0] stall_cnt_q;
    logic        eff_rs1;
    logic        eff_rs2;
    logic        eff_rd;
    logic        hazard;
    logic        slot_free;
    logic        accept;
    logic        set_en;
    logic        flush_clr_en;

    assign rf_rs1_o = dec_rs1_i;
    assign rf_rs2_o = dec_rs2_i;

    assign hazard = (dec_use_rs1_i && (dec_rs1_i != '0) && eff_rs1)
                 || (dec_use_rs2_i && (dec_rs2_i != '0) && eff_rs2)
                 || (dec_wr_i      && (dec_rd_i  != '0) && eff_rd);

    assign slot_free   = !ex_valid_q || ex_ready_i;
    assign dec_ready_o = slot_free && !hazard && !flush_i;
    assign accept      = dec_valid_i && dec_ready_o;

    assign set_en       = accept && dec_wr_i && (dec_rd_i != '0);
    // a flushed writer never reaches writeback, so release its claim here
    assign flush_clr_en = flush_i && ex_valid_q && bundle_q.wr && (bundle_q.rd != '0);

    of_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .set_en        (set_en),
        .set_idx       (dec_rd_i),
        .flush_clr_en  (flush_clr_en),
        .flush_clr_idx (bundle_q.rd),
        .wb_valid      (wb_valid_i),
        .wb_rd         (wb_rd_i),
        .rs1           (dec_rs1_i),
        .rs2           (dec_rs2_i),
        .rd            (dec_rd_i),
        .eff_rs1       (eff_rs1),
        .eff_rs2       (eff_rs2),
        .eff_rd        (eff_rd)
    );

    always_comb begin
        bundle_d      = bundle_q;
        bundle_d.op1  = operand_select(dec_rs1_i, rf_rs1_data_i, wb_valid_i, wb_rd_i, wb_data_i);
        bundle_d.op2  = operand_select(dec_rs2_i, rf_rs2_data_i, wb_valid_i, wb_rd_i, wb_data_i);
        bundle_d.rd   = dec_rd_i;
        bundle_d.wr   = dec_wr_i;
        bundle_d.ctrl = dec_ctrl_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q   <= '0;
            ex_valid_q <= 1'b0;
        end else if (flush_i) begin
            ex_valid_q <= 1'b0;
        end else if (accept) begin
            bundle_q   <= bundle_d;
            ex_valid_q <= 1'b1;
        end else if (ex_ready_i) begin
            ex_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (dec_valid_i && !dec_ready_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign ex_valid_o  = ex_valid_q;
    assign ex_op1_o    = bundle_q.op1;
    assign ex_op2_o    = bundle_q.op2;
    assign ex_rd_o     = bundle_q.rd;
    assign ex_wr_o     = bundle_q.wr;
    assign ex_ctrl_o   = bundle_q.ctrl;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid_i;
    logic        dec_ready_o;
    logic [4:0]  dec_rs1_i;
    logic [4:0]  dec_rs2_i;
    logic        dec_use_rs1_i;
    logic        dec_use_rs2_i;
    logic [4:0]  dec_rd_i;
    logic        dec_wr_i;
    logic [15:0] dec_ctrl_i;
    logic [4:0]  rf_rs1_o;
    logic [4:0]  rf_rs2_o;
    logic [31:0] rf_rs1_data_i;
    logic [31:0] rf_rs2_data_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        flush_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] ex_op1_o;
    logic [31:0] ex_op2_o;
    logic [4:0]  ex_rd_o;
    logic        ex_wr_o;
    logic [15:0] ex_ctrl_o;
    logic [31:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [32];
    logic [86:0] exp_q [$];
    logic        exp_due = 1'b0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .dec_valid_i   (dec_valid_i),
        .dec_ready_o   (dec_ready_o),
        .dec_rs1_i     (dec_rs1_i),
        .dec_rs2_i     (dec_rs2_i),
        .dec_use_rs1_i (dec_use_rs1_i),
        .dec_use_rs2_i (dec_use_rs2_i),
        .dec_rd_i      (dec_rd_i),
        .dec_wr_i      (dec_wr_i),
        .dec_ctrl_i    (dec_ctrl_i),
        .rf_rs1_o      (rf_rs1_o),
        .rf_rs2_o      (rf_rs2_o),
        .rf_rs1_data_i (rf_rs1_data_i),
        .rf_rs2_data_i (rf_rs2_data_i),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .flush_i       (flush_i),
        .ex_valid_o    (ex_valid_o),
        .ex_ready_i    (ex_ready_i),
        .ex_op1_o      (ex_op1_o),
        .ex_op2_o      (ex_op2_o),
        .ex_rd_o       (ex_rd_o),
        .ex_wr_o       (ex_wr_o),
        .ex_ctrl_o     (ex_ctrl_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    // register file model: combinational read, write lands at the writeback edge
    assign rf_rs1_data_i = rf[rf_rs1_o];
    assign rf_rs2_data_i = rf[rf_rs2_o];

    always @(posedge clk) begin
        if (wb_valid_i && (wb_rd_i != 5'd0)) begin
            rf[wb_rd_i] <= wb_data_i;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_op(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_valid_i && (wb_rd_i == idx)) return wb_data_i;
        return rf[idx];
    endfunction

    // accepted bundles are predicted before the edge and compared one cycle later
    always begin
        @(negedge clk);
        #3;
        if (exp_due) begin
            exp_due = 1'b0;
            if (exp_q.size() == 0) begin
                check("bundle_queue", 128'd0, 128'd1);
            end else begin
                check("bundle", {41'd0, ex_valid_o, ex_op1_o, ex_op2_o, ex_rd_o, ex_wr_o, ex_ctrl_o},
                      {41'd0, exp_q.pop_front()});
            end
        end
        if (!rst && dec_valid_i && dec_ready_o) begin
            exp_q.push_back({1'b1, mdl_op(dec_rs1_i), mdl_op(dec_rs2_i), dec_rd_i, dec_wr_i, dec_ctrl_i});
            exp_due = 1'b1;
        end
    end

    task automatic cyc;
        @(negedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic [15:0] ctrl);
        dec_valid_i   = v;
        dec_rs1_i     = rs1;
        dec_rs2_i     = rs2;
        dec_use_rs1_i = u1;
        dec_use_rs2_i = u2;
        dec_rd_i      = rd;
        dec_wr_i      = wr;
        dec_ctrl_i    = ctrl;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] data);
        wb_valid_i = v;
        wb_rd_i    = rd;
        wb_data_i  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[0] = 32'h1234;
        rf[1] = 32'h11;
        rf[2] = 32'h22;
        rf[9] = 32'h99;
        rst = 1'b1;
        flush_i = 1'b0;
        ex_ready_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
        wb(0, 0, 0);
        repeat (3) @(posedge clk);

        // reset state
        cyc; rst = 1'b0; settle;
        check("rst_ex_valid", ex_valid_o, 0);
        check("rst_bundle", {ex_op1_o, ex_op2_o, ex_rd_o, ex_wr_o, ex_ctrl_o}, 0);
        check("rst_stall", stall_cnt_o, 0);
        check("rst_ready", dec_ready_o, 1);

        // basic issue
        cyc; drive(1, 1, 2, 1, 1, 0, 0, 16'h00A1); settle;
        check("t1_ready", dec_ready_o, 1);
        cyc; drive(0, 0, 0, 0, 0, 0, 0, 16'h0); settle;
        check("t1_op1", ex_op1_o, 32'h11);
        check("t1_op2", ex_op2_o, 32'h22);
        check("t1_stall", stall_cnt_o, 0);

        // RAW stall released by same-cycle writeback
        cyc; drive(1, 1, 2, 1, 1, 5, 1, 16'h00B2); settle;
        check("t2_wr_ready", dec_ready_o, 1);
        cyc; drive(1, 5, 0, 1, 0, 0, 0, 16'h00C3); settle;
        check("t2_stall_c2", dec_ready_o, 0);
        cyc; settle;
        check("t2_stall_c3", dec_ready_o, 0);
        cyc; wb(1, 5, 32'hDEADBEEF); settle;
        check("t2_release", dec_ready_o, 1);
        cyc; wb(0, 0, 0); drive(1, 5, 0, 1, 0, 0, 0, 16'h00C4); settle;
        check("t2_op1", ex_op1_o, 32'hDEADBEEF);
        check("t2_stall", stall_cnt_o, 2);
        check("t2_pending5_clear", dec_ready_o, 1);
        cyc; drive(0, 0, 0, 0, 0, 0, 0, 16'h0); settle;

        // x0 source and x0 destination
        cyc; drive(1, 0, 1, 1, 1, 0, 1, 16'h00D1); settle;
        check("t3_ready", dec_ready_o, 1);
        cyc; drive(1, 0, 0, 1, 1, 0, 0, 16'h00D2); settle;
        check("t3_op1_zero", ex_op1_o, 0);
        check("t3_b2b_ready", dec_ready_o, 1);
        cyc; drive(0, 0, 0, 0, 0, 0, 0, 16'h0); settle;

        // backpressure
        cyc; drive(1, 1, 2, 1, 1, 0, 0, 16'h00D4); settle;
        check("t4_ready", dec_ready_o, 1);
        for (int k = 0; k < 3; k++) begin
            cyc; ex_ready_i = 1'b0; drive(1, 2, 1, 1, 1, 0, 0, 16'h00E5); settle;
            check("t4_bp_ready", dec_ready_o, 0);
            check("t4_bp_hold", {ex_valid_o, ex_op1_o, ex_op2_o, ex_ctrl_o}, {1'b1, 32'h11, 32'h22, 16'h00D4});
        end
        cyc; ex_ready_i = 1'b1; settle;
        check("t4_stall", stall_cnt_o, 5);
        check("t4_release", dec_ready_o, 1);
        cyc; drive(0, 0, 0, 0, 0, 0, 0, 16'h0); settle;
        check("t4_new_op1", ex_op1_o, 32'h22);

        // WAW: set wins over same-cycle writeback clear
        cyc; drive(1, 1, 2, 1, 1, 7, 1, 16'h00F6); settle;
        check("t5_ready", dec_ready_o, 1);
        cyc; drive(1, 0, 0, 0, 0, 7, 1, 16'h0007); settle;
        check("t5_waw_stall", dec_ready_o, 0);
        cyc; wb(1, 7, 32'h77); settle;
        check("t5_waw_release", dec_ready_o, 1);
        cyc; wb(0, 0, 0); drive(1, 7, 0, 1, 0, 0, 0, 16'h0008); settle;
        check("t5_pending7_kept", dec_ready_o, 0);
        cyc; wb(1, 7, 32'h777); settle;
        check("t5_reader_release", dec_ready_o, 1);
        cyc; wb(0, 0, 0); drive(0, 0, 0, 0, 0, 0, 0, 16'h0); settle;
        check("t5_op1", ex_op1_o, 32'h777);
        check("t5_stall", stall_cnt_o, 7);

        // flush of a held writer releases its pending bit
        cyc; drive(1, 1, 2, 1, 1, 9, 1, 16'h0099); settle;
        check("t6_ready", dec_ready_o, 1);
        cyc; ex_ready_i = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 16'h0); settle;
        check("t6_held", {ex_valid_o, ex_rd_o, ex_wr_o}, {1'b1, 5'd9, 1'b1});
        cyc; flush_i = 1'b1; drive(1, 9, 0, 1, 0, 0, 0, 16'h009A); settle;
        check("t6_flush_ready", dec_ready_o, 0);
        cyc; flush_i = 1'b0; ex_ready_i = 1'b1; settle;
        check("t6_flushed", ex_valid_o, 0);
        check("t6_pending9_clear", dec_ready_o, 1);
        cyc; drive(0, 0, 0, 0, 0, 0, 0, 16'h0); settle;
        check("t6_op1", ex_op1_o, 32'h99);
        check("t6_stall", stall_cnt_o, 8);
        cyc; settle;
        check("drain", ex_valid_o, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage that reads the register file on behalf of the execute stage. Accepts decoded instructions over a valid/ready handshake and drives the register-file read addresses. Bypasses same-cycle writeback data. Tracks outstanding register writes in a scoreboard so RAW and WAW hazards stall. Sits between decode and execute, beside the register file, and presents a registered operand bundle downstream.

## Interface
- NUM_REGS, 32, number of architectural registers (index width 5)
- XLEN, 32, operand width
- CTRL_W, 16, opaque decode-control bits passed through to execute
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- dec_valid_i  in  1  decoded instruction valid
- dec_ready_o  out  1  stage accepts instruction this cycle
- dec_rs1_i, dec_rs2_i  in  5  source register indices
- dec_use_rs1_i, dec_use_rs2_i  in  1  source actually read
- dec_rd_i  in  5  destination index
- dec_wr_i  in  1  instruction writes rd
- dec_ctrl_i  in  CTRL_W  pass-through control
- rf_rs1_o, rf_rs2_o  out  5  register-file read addresses (combinational from dec_rs*_i)
- rf_rs1_data_i, rf_rs2_data_i  in  XLEN  register-file read data (combinational read)
- wb_valid_i  in  1  writeback this cycle (same beat the register file writes)
- wb_rd_i  in  5  writeback destination
- wb_data_i  in  XLEN  writeback data
- flush_i  in  1  discard the held output bundle
- ex_valid_o  out  1  operand bundle valid
- ex_ready_i  in  1  execute consumes bundle
- ex_op1_o, ex_op2_o  out  XLEN  operands
- ex_rd_o  out  5; ex_wr_o  out  1; ex_ctrl_o  out  CTRL_W  pass-through
- stall_cnt_o  out  32  saturating count of cycles with dec_valid_i=1 and dec_ready_o=0

## Operation
- Scoreboard: pending[NUM_REGS]; pending[0] is constant 0.
- wb_hit(r) = wb_valid_i && wb_rd_i==r && r!=0.
- Effective pending: eff(r) = pending[r] && !wb_hit(r).
- Hazard:
  - (use_rs1 && rs1!=0 && eff(rs1))
  - || (use_rs2 && rs2!=0 && eff(rs2))
  - || (dec_wr_i && rd!=0 && eff(rd)), the WAW case, so each register has at most one writer in flight.
- slot_free = !ex_valid_o || ex_ready_i.
- dec_ready_o = slot_free && !hazard && !flush_i.
- accept = dec_valid_i && dec_ready_o.
- Operand select per source, in priority order:
  1. index 0 gives 0.
  2. wb_hit gives wb_data_i.
  3. Otherwise rf_rs*_data_i.
  - Unused sources still follow this rule; the value is don't-care for execute.
- On accept:
  - Register op1/op2/rd/wr/ctrl.
  - ex_valid_o<=1.
  - If dec_wr_i && rd!=0, set pending[rd].
- Else if ex_ready_i: ex_valid_o<=0; data registers hold.
- Writeback clears pending[wb_rd_i]. When a new accept sets the same index in the same cycle, the set wins.
- flush_i:
  - ex_valid_o<=0.
  - If the held bundle had ex_valid_o && ex_wr_o && ex_rd_o!=0, clear pending[ex_rd_o], because the flushed instruction will never write back.
  - No accept in a flush cycle.
  - Instructions already past execute still write back normally.
- stall_cnt_o increments each cycle where dec_valid_i && !dec_ready_o; it saturates at 0xFFFF_FFFF.
- Reset:
  - ex_valid_o=0, all pending=0, stall_cnt_o=0.
  - ex_op1_o/ex_op2_o/ex_rd_o/ex_wr_o/ex_ctrl_o=0.
  - dec_ready_o=1 when flush_i=0.
- Upstream rule: dec_* fields stay stable while dec_valid_i && !dec_ready_o. dec_ready_o depends combinationally on dec fields, but never on dec_valid_i.

## Timing
- Issue latency: 1 cycle. Bundle accepted at edge N is on ex_* after edge N.
- Full throughput with no hazard: one instruction per cycle while ex_ready_i=1.
- The bypass is required because the register-file write lands at the same edge as the accept.
- RAW release:
  - A reader stalled on rd issues in the cycle wb_valid_i for rd is asserted, with the wb_data_i operand.
  - It does not wait a cycle beyond that.
- Backpressure: with ex_valid_o=1 and ex_ready_i=0, all ex_* outputs hold and dec_ready_o=0.
- rst has priority over flush_i and accept.

## Structure
- Shared package:
  - XLEN, NUM_REGS, reg index typedef (logic [4:0]), CTRL_W.
  - Operand-bundle struct: op1, op2, rd, wr, ctrl.
- Sub-module of_scoreboard:
  - Pending vector with set/clear ports (set wins).
  - Effective-pending lookup for rs1, rs2 and rd, including the wb_hit mask.
- Top level holds the handshake, operand mux, output register and stall counter.

## Test plan
- Reset, register file returns 0x11/0x22 for rs1=1/rs2=2, ex_ready_i=1, one instruction → next cycle ex_valid_o=1, op1=0x11, op2=0x22, stall_cnt_o=0.
- Writer rd=5 issued, then reader rs1=5 held valid; wb rd=5 data 0xDEADBEEF at cycle 4 → dec_ready_o=0 in cycles 2–3, accept in cycle 4, op1=0xDEADBEEF, stall_cnt_o=2, pending[5]=0.
- rs1=0 with register file returning 0x1234 → op1=0; writer rd=0 → no pending set, and a follow-on rs1=0 reader issues back-to-back.
- ex_ready_i=0 for 3 cycles with a valid bundle and a new dec_valid_i → ex_* stable, dec_ready_o=0, stall_cnt_o=3; then ex_ready_i=1 → new bundle next cycle.
- rd=7 pending, second writer rd=7 → stalls until wb rd=7; in the wb cycle it is accepted and pending[7] stays 1 (set wins).
- Bundle with wr=1, rd=9 held under backpressure, flush_i=1 → ex_valid_o=0, pending[9]=0; a reader of rs1=9 issues immediately afterwards using register-file data.
